// File: rtl/mux_4x1_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// mux_4x1_rr_arbiter_if : handshake bundle for the 4:1 round-robin collector
// Revision 1.0
// ============================================================================
interface mux_4x1_rr_arbiter_if #(
    parameter int DW = 8
);
    logic [3:0]      in_valid;
    logic [4*DW-1:0] in_data;
    logic [3:0]      in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_sel;
    logic            out_ready;
    logic [15:0]     xfer_count;

    // Collector side
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sel,
        output xfer_count
    );

    // Producer / consumer side
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sel,
        input  xfer_count
    );
endinterface
`default_nettype wire

// File: rtl/mux_4x1_rr_arbiter.sv
`default_nettype none
// ============================================================================
// mux_4x1_rr_arbiter : four valid/ready streams merged round-robin into one
//                      registered output beat tagged with its source index
// Revision 1.0
// ============================================================================
module mux_4x1_rr_arbiter #(
    parameter int DW = 8
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    mux_4x1_rr_arbiter_if.slave bus
);
    localparam logic [15:0] COUNT_MAX = 16'hFFFF;
    localparam logic [1:0]  LAST_RST  = 2'd3;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [1:0]    last;
    logic [DW-1:0] hold_data;
    logic [1:0]    hold_sel;
    logic [15:0]   count;

    logic [3:0]    grant;
    logic [1:0]    grant_idx;
    logic          grant_any;
    logic          slot_free;
    logic          in_xfer;
    logic [DW-1:0] grant_data;

    // First valid channel after the last winner, wrapping back to it last.
    always_comb begin : grant_search
        logic [1:0] cand;
        grant_any = 1'b0;
        grant_idx = last;
        cand      = last;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!grant_any && bus.in_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        grant = grant_any ? (4'b0001 << grant_idx) : 4'b0000;
    end

    assign slot_free  = (state == EMPTY) || bus.out_ready;
    // rst_n term keeps every ready low while reset is held.
    assign bus.in_ready = grant & {4{slot_free & rst_n}};
    assign in_xfer    = |bus.in_ready;
    assign grant_data = bus.in_data[grant_idx*DW +: DW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (!in_xfer && bus.out_ready) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data <= '0;
            hold_sel  <= 2'd0;
            last      <= LAST_RST;
            count     <= 16'd0;
        end else if (in_xfer) begin
            hold_data <= grant_data;
            hold_sel  <= grant_idx;
            last      <= grant_idx;
            if (count != COUNT_MAX) begin
                count <= count + 16'd1;
            end
        end
    end

    assign bus.out_valid  = (state == FULL);
    assign bus.out_data   = hold_data;
    assign bus.out_sel    = hold_sel;
    assign bus.xfer_count = count;

endmodule
`default_nettype wire

// File: tb/tb_mux_4x1_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mux_4x1_rr_arbiter : directed vector bench for the 4:1 round-robin collector
// Revision 1.0
// ============================================================================
module tb_mux_4x1_rr_arbiter;
    localparam int DW = 8;
    localparam logic [31:0] D  = 32'h13121110;
    localparam logic [31:0] DA = 32'h00A50000;
    localparam logic [31:0] DB = 32'h13123C10;

    typedef struct {
        logic        pre_rst;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        ready;
        logic [3:0]  exp_ready;
        logic        exp_ov;
        logic [7:0]  exp_od;
        logic [1:0]  exp_sel;
        logic [15:0] exp_cnt;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl[$];

    mux_4x1_rr_arbiter_if #(.DW(DW)) bus ();

    mux_4x1_rr_arbiter #(.DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic [3:0] v, logic [31:0] d, logic rdy,
                                logic [3:0] er, logic eov, logic [7:0] eod,
                                logic [1:0] esel, logic [15:0] ec);
        vec_t t;
        t.pre_rst = r;   t.valid = v;    t.data = d;      t.ready = rdy;
        t.exp_ready = er; t.exp_ov = eov; t.exp_od = eod;  t.exp_sel = esel;
        t.exp_cnt = ec;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic apply(input vec_t v, input string tag);
        if (v.pre_rst) do_reset();
        @(negedge clk);
        bus.in_valid  = v.valid;
        bus.in_data   = v.data;
        bus.out_ready = v.ready;
        #1;
        chk({tag, " in_ready"}, 32'(bus.in_ready), 32'(v.exp_ready));
        @(posedge clk);
        #1;
        chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(v.exp_ov));
        chk({tag, " out_data"}, 32'(bus.out_data), 32'(v.exp_od));
        chk({tag, " out_sel"}, 32'(bus.out_sel), 32'(v.exp_sel));
        chk({tag, " xfer_count"}, 32'(bus.xfer_count), 32'(v.exp_cnt));
    endtask

    initial begin
        // Single channel 2
        tbl.push_back(mk(1, 4'b0100, DA, 1, 4'b0100, 1, 8'hA5, 2, 1));
        // All channels, fairness 0,1,2,3,0,1,2,3
        tbl.push_back(mk(1, 4'b1111, D, 1, 4'b0001, 1, 8'h10, 0, 1));
        tbl.push_back(mk(0, 4'b1111, D, 1, 4'b0010, 1, 8'h11, 1, 2));
        tbl.push_back(mk(0, 4'b1111, D, 1, 4'b0100, 1, 8'h12, 2, 3));
        tbl.push_back(mk(0, 4'b1111, D, 1, 4'b1000, 1, 8'h13, 3, 4));
        tbl.push_back(mk(0, 4'b1111, D, 1, 4'b0001, 1, 8'h10, 0, 5));
        tbl.push_back(mk(0, 4'b1111, D, 1, 4'b0010, 1, 8'h11, 1, 6));
        tbl.push_back(mk(0, 4'b1111, D, 1, 4'b0100, 1, 8'h12, 2, 7));
        tbl.push_back(mk(0, 4'b1111, D, 1, 4'b1000, 1, 8'h13, 3, 8));
        // Backpressure holding channel 1 / 8'h3C
        tbl.push_back(mk(0, 4'b0010, DB, 1, 4'b0010, 1, 8'h3C, 1, 9));
        tbl.push_back(mk(0, 4'b1111, DB, 0, 4'b0000, 1, 8'h3C, 1, 9));
        tbl.push_back(mk(0, 4'b1111, DB, 0, 4'b0000, 1, 8'h3C, 1, 9));
        tbl.push_back(mk(0, 4'b1111, DB, 0, 4'b0000, 1, 8'h3C, 1, 9));
        tbl.push_back(mk(0, 4'b1111, DB, 1, 4'b0100, 1, 8'h12, 2, 10));
        // Channels 0 and 3, starting from last = 3
        tbl.push_back(mk(0, 4'b1000, D, 1, 4'b1000, 1, 8'h13, 3, 11));
        tbl.push_back(mk(0, 4'b1001, D, 1, 4'b0001, 1, 8'h10, 0, 12));
        tbl.push_back(mk(0, 4'b1001, D, 1, 4'b1000, 1, 8'h13, 3, 13));
        tbl.push_back(mk(0, 4'b1001, D, 1, 4'b0001, 1, 8'h10, 0, 14));
        tbl.push_back(mk(0, 4'b1001, D, 1, 4'b1000, 1, 8'h13, 3, 15));
        // Drain, then idle with and without out_ready
        tbl.push_back(mk(0, 4'b0000, D, 1, 4'b0000, 0, 8'h13, 3, 15));
        tbl.push_back(mk(0, 4'b0000, D, 1, 4'b0000, 0, 8'h13, 3, 15));
        tbl.push_back(mk(0, 4'b0000, D, 0, 4'b0000, 0, 8'h13, 3, 15));

        // Reset state, with all inputs valid to show ready is gated
        bus.in_valid  = 4'b1111;
        bus.in_data   = D;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst out_data", 32'(bus.out_data), 32'd0);
        chk("rst out_sel", 32'(bus.out_sel), 32'd0);
        chk("rst xfer_count", 32'(bus.xfer_count), 32'd0);
        chk("rst in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 4'b0000;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Mid-operation reset with a held beat and xfer_count = 5
        apply(mk(1, 4'b1111, D, 1, 4'b0001, 1, 8'h10, 0, 1), "mr0");
        apply(mk(0, 4'b1111, D, 1, 4'b0010, 1, 8'h11, 1, 2), "mr1");
        apply(mk(0, 4'b1111, D, 1, 4'b0100, 1, 8'h12, 2, 3), "mr2");
        apply(mk(0, 4'b1111, D, 1, 4'b1000, 1, 8'h13, 3, 4), "mr3");
        apply(mk(0, 4'b0010, D, 1, 4'b0010, 1, 8'h11, 1, 5), "mr4");
        #2;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        #1;
        chk("async out_valid", 32'(bus.out_valid), 32'd0);
        chk("async xfer_count", 32'(bus.xfer_count), 32'd0);
        chk("async out_sel", 32'(bus.out_sel), 32'd0);
        chk("async out_data", 32'(bus.out_data), 32'd0);
        chk("async in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 4'b0000;
        @(posedge clk);
        #1;
        chk("release no beat", 32'(bus.out_valid), 32'd0);
        apply(mk(0, 4'b0011, D, 1, 4'b0001, 1, 8'h10, 0, 1), "post_rst");

        // Saturation: 65534 back-to-back transfers then three more
        do_reset();
        @(negedge clk);
        bus.in_valid  = 4'b1111;
        bus.in_data   = D;
        bus.out_ready = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat pre", 32'(bus.xfer_count), 32'h0000FFFE);
        apply(mk(0, 4'b1111, D, 1, 4'b0100, 1, 8'h12, 2, 16'hFFFF), "sat0");
        apply(mk(0, 4'b1111, D, 1, 4'b1000, 1, 8'h13, 3, 16'hFFFF), "sat1");
        apply(mk(0, 4'b1111, D, 1, 4'b0001, 1, 8'h10, 0, 16'hFFFF), "sat2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mux_4x1_rr_arbiter.md
# mux_4x1_rr_arbiter

Four-channel collector that merges four independent valid/ready input streams onto one registered output stream. Each beat carries the 2-bit index of the source channel (`out_sel`), so a downstream 1x4 demux driven by that index can return results to the originating channel. Arbitration is round-robin; the block sits wherever several producers share a single consumer or datapath.

## Interface
- `DW`, 8, data width of every input channel and of the output
- `clk` input 1 rising-edge clock
- `rst_n` input 1 asynchronous active-low reset
- `in_valid` input 4 per-channel valid; bit i belongs to channel i
- `in_data` input 4*DW channel i data in bits [i*DW +: DW]
- `in_ready` output 4 per-channel ready; at most one bit high per cycle
- `out_valid` output 1 output beat present
- `out_data` output DW registered data of the accepted beat
- `out_sel` output 2 index of the channel that supplied `out_data`
- `out_ready` input 1 consumer accepts the beat when high with `out_valid`
- `xfer_count` output 16 number of beats accepted from inputs, saturating at 16'hFFFF

## Operation
- Holding register: a single entry, holding `out_valid`, `out_data` and `out_sel`.
- `slot_free` = ~`out_valid` | `out_ready`.
- Priority pointer `last` (2 bits) records the most recently granted channel. Search order is `last`+1, `last`+2, `last`+3, `last`, all modulo 4.
- `grant` is one-hot, or zero. It selects the first channel in search order with `in_valid` high. `grant` is combinational from `in_valid` and `last`.
- `in_ready[i]` = `grant[i]` & `slot_free`. No `in_ready` bit depends on its own channel's `in_valid` beyond the grant search.
- Input transfer on channel i: `in_valid[i]` & `in_ready[i]`. On the next edge:
  - `out_data` <= channel i data
  - `out_sel` <= i
  - `out_valid` <= 1
  - `last` <= i
  - `xfer_count` increments unless it already equals 16'hFFFF
- Output transfer: `out_valid` & `out_ready`. If there is no simultaneous input transfer, `out_valid` <= 0, and `out_data` and `out_sel` hold their values.
- Simultaneous output and input transfer in the same cycle: the register reloads with the new beat and `out_valid` stays 1. There is no bubble.
- If `out_valid`=1 and `out_ready`=0, the output register holds and all `in_ready` bits are 0. `last` does not move.
- `last` changes only on an input transfer. A channel that loses arbitration keeps its claim and must hold its data stable.
- State summary: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
  - EMPTY→FULL on input transfer.
  - FULL→EMPTY on output transfer without an input transfer.
  - FULL→FULL on hold, or on simultaneous output and input transfer.

## Timing
- Reset (async assert, sync release):
  - `out_valid`=0
  - `out_data`=0
  - `out_sel`=0
  - `last`=3, so channel 0 has first priority
  - `xfer_count`=0
  - `in_ready`=0 while `rst_n`=0
- Latency: an input accepted at edge N appears at the output with `out_valid`=1 immediately after edge N.
- Throughput: 1 beat per cycle while `out_ready`=1.
- Fairness: with all four channels continuously valid and `out_ready`=1, grant order is 0,1,2,3,0,… Any waiting channel is served within 4 input transfers.
- Reset asserted mid-operation: a held beat is discarded, the pointer returns to 3 and the counter clears, all immediately. No beat is emitted on release until a new input transfer occurs.
- `out_ready` may be high while `out_valid`=0. This has no effect.

## Test plan
- Reset, then channel 2 alone with `in_valid`=4'b0100 and data 8'hA5, `out_ready`=1:
  - `in_ready`=4'b0100
  - next cycle `out_valid`=1, `out_data`=8'hA5, `out_sel`=2
  - `xfer_count`=1
- All channels valid with data 8'h10, 8'h11, 8'h12, 8'h13, `out_ready`=1 for 8 cycles:
  - `out_sel` sequence is 0,1,2,3,0,1,2,3
  - `out_data` follows the channel data
  - `out_valid` stays high with no gaps
  - `xfer_count`=8
- Backpressure: the output holds channel 1 data 8'h3C while `out_ready`=0 for 3 cycles with all inputs valid:
  - `in_ready`=0 throughout
  - `out_data` and `out_sel` stay stable at 8'h3C and 1
  - when `out_ready` rises, channel 2 is granted in the same cycle and appears next cycle
- Channels 0 and 3 valid, last grant 3:
  - channel 0 is granted first, then channel 3
  - if channel 0 stays valid, grants alternate 3,0,3
- Assert `rst_n`=0 while `out_valid`=1 and `xfer_count`=5:
  - `out_valid`, `xfer_count`, `out_sel` and `in_ready` go to 0 without waiting for a clock edge
  - after release with channels 1 and 0 valid, channel 0 is granted first
- Force `xfer_count` to 16'hFFFE, then perform 3 transfers: the count reads FFFF, FFFF, FFFF.
